pipe_out_streamer: RTL and testbench

- Target-side data source for the host interface: buffers 32-bit measurement words produced in the okClk domain and delivers them to the host through a block-throttled pipe-out endpoint.
- Sits between the measurement datapath (push side) and the okBTPipeOut endpoint (read side) hanging off the okHE/okEH bus.
- Owns the FIFO, block-ready throttling and error flags.

---
 rtl/pipe_out_pkg.sv | 6 +
 rtl/sync_fifo_fwft.sv | 49 ++++
 rtl/pipe_out_streamer.sv | 92 +++++++++
 tb/tb_pipe_out_streamer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_out_pkg.sv
// pipe_out_pkg: shared types and constants for the pipe-out streamer
package pipe_out_pkg;
    localparam int DW = 32;
    localparam logic [DW-1:0] UNDERRUN_DEFAULT = 32'hDEAD_BEEF;
    typedef enum logic [1:0] {ST_IDLE, ST_READY, ST_BURST} stateT;
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock first-word-fall-through FIFO with occupancy count
module sync_fifo_fwft #(
    parameter int DW = 32,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wrData,
    output logic [DW-1:0] rdData,
    output logic [AW:0]   fill,
    output logic          full,
    output logic          empty,
    output logic          pushOk,
    output logic          popOk
);
    logic [DW-1:0] mem [2**AW];
    logic [AW:0]   wrPtr;
    logic [AW:0]   rdPtr;

    assign fill   = wrPtr - rdPtr;
    assign full   = fill[AW];
    assign empty  = fill == '0;
    assign popOk  = pop && !empty;
    // a pop on a full FIFO frees the slot the simultaneous push lands in
    assign pushOk = push && (!full || pop);
    assign rdData = mem[rdPtr[AW-1:0]];

    // pointer update; clear wins over push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else if (clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + 1'b1;
            if (popOk) rdPtr <= rdPtr + 1'b1;
        end
    end

    // storage write at the tail
    always_ff @(posedge clk) begin
        if (pushOk && !clear) mem[wrPtr[AW-1:0]] <= wrData;
    end
endmodule

// File: rtl/pipe_out_streamer.sv
// pipe_out_streamer: FIFO-backed block-throttled pipe-out data source
module pipe_out_streamer
    import pipe_out_pkg::*;
#(
    parameter int            DEPTH_LOG2    = 10,
    parameter int            BLOCK_WORDS   = 256,
    parameter logic [DW-1:0] UNDERRUN_WORD = UNDERRUN_DEFAULT
) (
    input  logic                  okClk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [DW-1:0]         in_data,
    output logic                  in_ready,
    input  logic                  ep_read,
    output logic [DW-1:0]         ep_dataout,
    output logic                  ep_ready,
    input  logic                  ep_blockstrobe,
    output logic [DEPTH_LOG2:0]   fill_level,
    output logic                  overflow,
    output logic                  underrun,
    output logic [15:0]           block_count
);
    localparam int CW = $clog2(BLOCK_WORDS) + 1;
    localparam logic [DEPTH_LOG2:0] BLK_FILL = (DEPTH_LOG2 + 1)'(BLOCK_WORDS);
    localparam logic [CW-1:0] LAST_CNT = CW'(BLOCK_WORDS - 1);

    logic [DW-1:0]       headWord;
    logic                full;
    logic                empty;
    logic                pushOk;
    logic                popOk;
    logic [DEPTH_LOG2:0] fillNext;
    logic [CW-1:0]       wordCnt;
    stateT               state;

    sync_fifo_fwft #(.DW(DW), .AW(DEPTH_LOG2)) fifo (
        .clk(okClk), .rst(rst), .clear(clear),
        .push(in_valid), .pop(ep_read), .wrData(in_data),
        .rdData(headWord), .fill(fill_level), .full(full), .empty(empty),
        .pushOk(pushOk), .popOk(popOk)
    );

    assign in_ready   = !full;
    assign ep_dataout = empty ? (ep_read ? UNDERRUN_WORD : '0) : headWord;
    // occupancy after this cycle's push/pop, used to decide re-arming at block end
    assign fillNext   = fill_level + (DEPTH_LOG2 + 1)'(pushOk) - (DEPTH_LOG2 + 1)'(popOk);

    // block-ready FSM with sticky flags and completed-block counter
    always_ff @(posedge okClk or posedge rst) begin
        if (rst || clear) begin
            state       <= ST_IDLE;
            ep_ready    <= 1'b0;
            wordCnt     <= '0;
            block_count <= '0;
            overflow    <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            if (in_valid && !pushOk) overflow <= 1'b1;
            if (ep_read && empty) underrun <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (fill_level >= BLK_FILL) begin
                        state    <= ST_READY;
                        ep_ready <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (ep_blockstrobe || ep_read) begin
                        state    <= ST_BURST;
                        ep_ready <= 1'b0;
                        wordCnt  <= CW'(ep_read);
                    end
                end
                ST_BURST: begin
                    if (ep_read && wordCnt == LAST_CNT) begin
                        block_count <= block_count + 1'b1;
                        wordCnt     <= '0;
                        state       <= fillNext >= BLK_FILL ? ST_READY : ST_IDLE;
                        ep_ready    <= fillNext >= BLK_FILL;
                    end else if (ep_read) begin
                        wordCnt <= wordCnt + 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    ep_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_out_streamer.sv
// tb_pipe_out_streamer: directed + randomized check against a queue model
module tb_pipe_out_streamer;
    localparam int DEPTH = 1024;
    localparam logic [31:0] UW = 32'hDEAD_BEEF;

    logic        okClk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        ep_read = 1'b0;
    logic [31:0] ep_dataout;
    logic        ep_ready;
    logic        ep_blockstrobe = 1'b0;
    logic [10:0] fill_level;
    logic        overflow;
    logic        underrun;
    logic [15:0] block_count;

    logic [31:0] q[$];
    bit          mOvf;
    bit          mUnd;
    int          total = 0;
    int          passed = 0;

    pipe_out_streamer dut (
        .okClk(okClk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ep_read(ep_read), .ep_dataout(ep_dataout), .ep_ready(ep_ready),
        .ep_blockstrobe(ep_blockstrobe), .fill_level(fill_level),
        .overflow(overflow), .underrun(underrun), .block_count(block_count)
    );

    always #5 okClk = ~okClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // one clock cycle of stimulus; the queue model follows the FIFO rules
    task automatic cyc(input bit v, input logic [31:0] d, input bit r, input bit s, input bit c);
        bit pOk;
        bit wOk;
        in_valid = v; in_data = d; ep_read = r; ep_blockstrobe = s; clear = c;
        #1;
        if (r && !c) begin
            if (q.size() != 0) chk("dataout", ep_dataout, q[0]);
            else chk("dataout_underrun", ep_dataout, UW);
        end
        pOk = r && q.size() != 0;
        wOk = v && (q.size() < DEPTH || pOk);
        @(posedge okClk);
        #1;
        in_valid = 0; in_data = '0; ep_read = 0; ep_blockstrobe = 0; clear = 0;
        if (c) begin
            q.delete(); mOvf = 0; mUnd = 0;
        end else begin
            if (pOk) void'(q.pop_front());
            if (wOk) q.push_back(d);
            if (v && !wOk) mOvf = 1;
            if (r && !pOk) mUnd = 1;
        end
    endtask

    task automatic pushRand(input int n);
        for (int i = 0; i < n; i++) cyc(1, $urandom, 0, 0, 0);
    endtask

    task automatic readN(input int n);
        for (int i = 0; i < n; i++) cyc(0, '0, 1, 0, 0);
    endtask

    task automatic checkModel(input string tag);
        chk({tag, "_fill"}, 32'(fill_level), 32'(q.size()));
        chk({tag, "_ovf"}, 32'(overflow), 32'(mOvf));
        chk({tag, "_und"}, 32'(underrun), 32'(mUnd));
    endtask

    initial begin
        repeat (2) @(posedge okClk);
        #1 rst = 0;
        chk("rst_ep_ready", 32'(ep_ready), 0);
        chk("rst_dataout", ep_dataout, 0);
        chk("rst_block_count", 32'(block_count), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        checkModel("rst");

        // block 0..255, ep_ready one cycle after threshold
        for (int i = 0; i < 256; i++) cyc(1, 32'(i), 0, 0, 0);
        chk("thr_fill", 32'(fill_level), 256);
        chk("thr_ready_lat", 32'(ep_ready), 0);
        cyc(0, '0, 0, 0, 0);
        chk("thr_ready", 32'(ep_ready), 1);
        cyc(0, '0, 0, 1, 0);
        chk("burst_ready_low", 32'(ep_ready), 0);
        for (int i = 0; i < 256; i++) begin
            chk("seq_data", ep_dataout, 32'(i));
            cyc(0, '0, 1, 0, 0);
        end
        chk("b1_count", 32'(block_count), 1);
        chk("b1_ready", 32'(ep_ready), 0);
        cyc(0, '0, 0, 0, 0);
        chk("b1_idle", 32'(ep_ready), 0);
        checkModel("b1");

        // 600 words, two blocks
        pushRand(600);
        cyc(0, '0, 0, 0, 0);
        chk("p600_ready", 32'(ep_ready), 1);
        cyc(0, '0, 0, 1, 0);
        readN(256);
        chk("p600_rearm", 32'(ep_ready), 1);
        chk("p600_fill344", 32'(fill_level), 344);
        readN(256);
        chk("p600_idle", 32'(ep_ready), 0);
        chk("p600_fill88", 32'(fill_level), 88);
        chk("p600_count", 32'(block_count), 3);
        cyc(0, '0, 0, 0, 1);
        chk("clr_count", 32'(block_count), 0);
        checkModel("clr1");

        // overflow: full plus 3
        pushRand(DEPTH);
        chk("full_in_ready", 32'(in_ready), 0);
        pushRand(3);
        checkModel("ovf");
        chk("ovf_fill", 32'(fill_level), 1024);
        readN(DEPTH);
        checkModel("ovf_drain");
        chk("ovf_blocks", 32'(block_count), 4);
        cyc(0, '0, 0, 0, 1);

        // simultaneous push/pop while full
        pushRand(DEPTH);
        cyc(1, $urandom, 1, 0, 0);
        chk("pp_fill", 32'(fill_level), 1024);
        chk("pp_in_ready", 32'(in_ready), 0);
        checkModel("pp");
        readN(DEPTH);
        checkModel("pp_drain");

        // underrun on empty FIFO, then push/read on empty, then normal data
        cyc(0, '0, 0, 0, 1);
        chk("empty_dataout", ep_dataout, 0);
        readN(2);
        chk("und_flag", 32'(underrun), 1);
        cyc(1, $urandom, 1, 0, 0);
        checkModel("und_pp");
        pushRand(1);
        readN(2);
        checkModel("und_after");
        cyc(0, '0, 0, 0, 1);
        chk("clr_und", 32'(underrun), 0);

        // async reset mid-burst
        pushRand(300);
        cyc(0, '0, 0, 0, 0);
        cyc(0, '0, 0, 1, 0);
        readN(100);
        #2 rst = 1;
        #1;
        chk("arst_fill", 32'(fill_level), 0);
        chk("arst_ep_ready", 32'(ep_ready), 0);
        chk("arst_dataout", ep_dataout, 0);
        chk("arst_count", 32'(block_count), 0);
        @(posedge okClk);
        #1 rst = 0;
        q.delete(); mOvf = 0; mUnd = 0;
        checkModel("arst");

        // clear mid-burst with nonzero block_count
        pushRand(300);
        cyc(0, '0, 0, 0, 0);
        cyc(0, '0, 0, 1, 0);
        readN(256);
        chk("cb_count", 32'(block_count), 1);
        pushRand(300);
        cyc(0, '0, 0, 0, 0);
        cyc(0, '0, 0, 1, 0);
        readN(50);
        cyc(0, '0, 0, 0, 1);
        chk("cb_count0", 32'(block_count), 0);
        chk("cb_ready", 32'(ep_ready), 0);
        checkModel("cb");
        cyc(0, '0, 0, 0, 0);
        chk("cb_idle", 32'(ep_ready), 0);

        // random traffic
        for (int i = 0; i < 800; i++)
            cyc($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) < 5, 0, 0);
        checkModel("rand");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
